// File: rtl/deserializador_param.sv
// ----------------------------------------------------------------------------
// deserializador_param
//
// Purpose:
//    Collects a serial bit stream into WIDTH-bit words and queues the finished
//    words in a small FIFO (DEPTH entries) for a consumer that takes them with
//    a simple ready/ack handshake.
//
// Parameters:
//    WIDTH      bits per assembled word (2..32)
//    DEPTH      number of finished words the output buffer can hold (1..8)
//    MSB_FIRST  0: first accepted bit lands in data_out[0]
//               1: first accepted bit lands in data_out[WIDTH-1]
//
// Ports:
//    clock_100KHz   in   single clock, everything changes on its rising edge
//    reset          in   synchronous, active-high reset
//    data_in        in   serial data bit
//    write_in       in   data_in is valid this cycle
//    status_out     out  high when a bit can be accepted this cycle
//    data_out       out  oldest finished word (zero while the buffer is empty)
//    data_ready     out  high when data_out holds a valid word
//    ack_in         in   consumer takes the word on data_out
//    level          out  number of words held in the buffer
//    overrun        out  sticky: a bit was offered while status_out was low
//    clear_overrun  in   clears overrun (a coincident new overrun wins)
// ----------------------------------------------------------------------------
module deserializador_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic                         clock_100KHz,
   input  logic                         reset,
   input  logic                         data_in,
   input  logic                         write_in,
   output logic                         status_out,
   output logic [WIDTH-1:0]             data_out,
   output logic                         data_ready,
   input  logic                         ack_in,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overrun,
   input  logic                         clear_overrun
);

   // Level must be able to represent DEPTH itself, pointers only 0..DEPTH-1.
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(WIDTH);

   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

   logic [CW-1:0]    bitCount_q, bitCount_d;
   logic [WIDTH-1:0] partial_q,  partial_d;
   logic [PW-1:0]    head_q,     head_d;
   logic [PW-1:0]    tail_q,     tail_d;
   logic [LW-1:0]    level_q,    level_d;
   logic             overrun_q,  overrun_d;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             accept;
   logic             push;
   logic             pop;
   logic             lastBit;
   logic [CW-1:0]    bitIndex;
   logic [WIDTH-1:0] assembled;

   // Output view of the buffer. status_out depends only on level, so a
   // half-built word never blocks acceptance; it only matters once the word
   // would actually need a free slot, which level already guarantees.
   always_comb begin
      status_out = (level_q < FULL_LVL);
      data_ready = (level_q != '0);
      data_out   = '0;
      if (data_ready) begin
         data_out = mem_q[head_q];
      end
      level      = level_q;
      overrun    = overrun_q;
   end

   // Bit assembly. The word including the bit arriving this cycle is built
   // here so a completing bit can be pushed straight into the buffer at the
   // same edge, giving one cycle of latency to data_out.
   always_comb begin
      accept    = write_in && status_out;
      pop       = ack_in && data_ready;
      lastBit   = (bitCount_q == LAST_BIT);
      push      = accept && lastBit;
      bitIndex  = bitCount_q;
      if (MSB_FIRST != 0) begin
         bitIndex = LAST_BIT - bitCount_q;
      end
      assembled           = partial_q;
      assembled[bitIndex] = data_in;
   end

   // Next-state for counter, pointers, level and the sticky overrun flag.
   // A push can never happen with the buffer full and a pop never with it
   // empty, so level stays within 0..DEPTH without extra saturation.
   always_comb begin
      bitCount_d = bitCount_q;
      partial_d  = partial_q;
      head_d     = head_q;
      tail_d     = tail_q;
      level_d    = level_q;
      overrun_d  = overrun_q;

      if (accept) begin
         if (lastBit) begin
            bitCount_d = '0;
            partial_d  = '0;
         end else begin
            bitCount_d = bitCount_q + 1'b1;
            partial_d  = assembled;
         end
      end

      if (push) begin
         tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + 1'b1;
      end

      if (pop) begin
         head_d = (head_q == LAST_SLOT) ? '0 : head_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // Clearing first lets a coincident new overrun event win.
      if (clear_overrun) begin
         overrun_d = 1'b0;
      end
      if (write_in && !status_out) begin
         overrun_d = 1'b1;
      end
   end

   // Control state registers; reset discards any half-built word.
   always_ff @(posedge clock_100KHz) begin
      if (reset) begin
         bitCount_q <= '0;
         partial_q  <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         level_q    <= '0;
         overrun_q  <= 1'b0;
      end else begin
         bitCount_q <= bitCount_d;
         partial_q  <= partial_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         level_q    <= level_d;
         overrun_q  <= overrun_d;
      end
   end

   // Word storage needs no reset: data_out is masked while level is zero.
   always_ff @(posedge clock_100KHz) begin
      if (push && !reset) begin
         mem_q[tail_q] <= assembled;
      end
   end

endmodule

// File: tb/tb_deserializador_param.sv
// ----------------------------------------------------------------------------
// tb_deserializador_param
//
// Directed bench for deserializador_param. Two instances share every input:
// one assembles LSB-first, the other MSB-first, both WIDTH=8, DEPTH=2.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_deserializador_param;

   logic       clock;
   logic       reset;
   logic       dataIn;
   logic       writeIn;
   logic       ackIn;
   logic       clearOverrun;

   logic       statusA, statusB;
   logic [7:0] dataOutA, dataOutB;
   logic       readyA, readyB;
   logic [1:0] levelA, levelB;
   logic       overrunA, overrunB;

   int         checkCount;
   int         errorCount;

   deserializador_param #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(0)) dutLsb (
      .clock_100KHz (clock),
      .reset        (reset),
      .data_in      (dataIn),
      .write_in     (writeIn),
      .status_out   (statusA),
      .data_out     (dataOutA),
      .data_ready   (readyA),
      .ack_in       (ackIn),
      .level        (levelA),
      .overrun      (overrunA),
      .clear_overrun(clearOverrun)
   );

   deserializador_param #(.WIDTH(8), .DEPTH(2), .MSB_FIRST(1)) dutMsb (
      .clock_100KHz (clock),
      .reset        (reset),
      .data_in      (dataIn),
      .write_in     (writeIn),
      .status_out   (statusB),
      .data_out     (dataOutB),
      .data_ready   (readyB),
      .ack_in       (ackIn),
      .level        (levelB),
      .overrun      (overrunB),
      .clear_overrun(clearOverrun)
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compares one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advances one rising edge and settles just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Sends a word as eight consecutive accepted bits, bit k of w in arrival
   // order k; optionally asserts ack_in together with the last bit.
   task automatic applyStimulus(input logic [7:0] w, input logic ackLast);
      for (int k = 0; k < 8; k++) begin
         dataIn  = w[k];
         writeIn = 1'b1;
         ackIn   = ackLast && (k == 7);
         tick();
      end
      writeIn = 1'b0;
      ackIn   = 1'b0;
      dataIn  = 1'b0;
   endtask

   // Pops one word.
   task automatic popWord();
      ackIn = 1'b1;
      tick();
      ackIn = 1'b0;
   endtask

   initial begin
      logic [7:0] pattern;
      checkCount   = 0;
      errorCount   = 0;
      reset        = 1'b1;
      dataIn       = 1'b0;
      writeIn      = 1'b0;
      ackIn        = 1'b0;
      clearOverrun = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst data_out", dataOutA, 0);
      checkOutput("rst data_ready", readyA, 0);
      checkOutput("rst level", levelA, 0);
      checkOutput("rst overrun", overrunA, 0);
      checkOutput("rst status_out", statusA, 1);

      // Bits 1,0,1,1,0,0,1,0 -> 0x4D (LSB first) / 0xB2 (MSB first)
      pattern = 8'b0100_1101;
      for (int k = 0; k < 8; k++) begin
         dataIn  = pattern[k];
         writeIn = 1'b1;
         tick();
         if (k == 6) begin
            checkOutput("7 bits ready", readyA, 0);
         end
      end
      writeIn = 1'b0;
      checkOutput("lsb data_out", dataOutA, 8'h4D);
      checkOutput("lsb data_ready", readyA, 1);
      checkOutput("lsb level", levelA, 1);
      checkOutput("msb data_out", dataOutB, 8'hB2);
      checkOutput("msb level", levelB, 1);
      popWord();
      checkOutput("pop level", levelA, 0);
      checkOutput("pop data_out", dataOutA, 0);

      // Fill DEPTH=2, then overrun
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      checkOutput("full level", levelA, 2);
      checkOutput("full status", statusA, 0);
      checkOutput("full head", dataOutA, 8'h11);
      dataIn  = 1'b1;
      writeIn = 1'b1;
      tick();
      writeIn = 1'b0;
      checkOutput("ovr flag", overrunA, 1);
      checkOutput("ovr level", levelA, 2);
      checkOutput("ovr head", dataOutA, 8'h11);
      clearOverrun = 1'b1;
      tick();
      clearOverrun = 1'b0;
      checkOutput("ovr cleared", overrunA, 0);
      clearOverrun = 1'b1;
      writeIn      = 1'b1;
      tick();
      clearOverrun = 1'b0;
      writeIn      = 1'b0;
      checkOutput("ovr clr+set", overrunA, 1);
      clearOverrun = 1'b1;
      tick();
      clearOverrun = 1'b0;
      checkOutput("ovr clr2", overrunA, 0);
      popWord();
      checkOutput("drain head", dataOutA, 8'h22);
      checkOutput("drain level", levelA, 1);
      popWord();
      checkOutput("drain empty", levelA, 0);

      // Push and pop at the same edge; dropped bits must not have shifted
      // the bit counter, and pointers have wrapped by now.
      applyStimulus(8'h11, 1'b0);
      checkOutput("word 11", dataOutA, 8'h11);
      applyStimulus(8'h22, 1'b1);
      checkOutput("pushpop level", levelA, 1);
      checkOutput("pushpop data", dataOutA, 8'h22);
      checkOutput("pushpop msb", dataOutB, 8'h44);
      popWord();
      checkOutput("pushpop empty", levelA, 0);

      // Reset mid-word discards the partial word
      for (int k = 0; k < 5; k++) begin
         dataIn  = 1'b1;
         writeIn = 1'b1;
         tick();
      end
      writeIn = 1'b0;
      reset   = 1'b1;
      tick();
      reset   = 1'b0;
      checkOutput("midrst level", levelA, 0);
      applyStimulus(8'hA5, 1'b0);
      checkOutput("midrst data", dataOutA, 8'hA5);
      checkOutput("midrst lvl1", levelA, 1);
      checkOutput("midrst msb", dataOutB, 8'hA5);

      // ack_in held with an empty buffer
      ackIn = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("ack empty level", levelA, 0);
         checkOutput("ack empty ready", readyA, 0);
         checkOutput("ack empty data", dataOutA, 0);
      end
      ackIn = 1'b0;
      applyStimulus(8'h3C, 1'b0);
      checkOutput("after ack idle", dataOutA, 8'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/deserializador_param.md
DESERIALIZADOR_PARAM -- requirements
Module: deserializador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per assembled word (legal range 2..32).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of completed words held in the output buffer (legal range 1..8).
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning bit order: 0 = first accepted bit lands in data_out[0]; 1 = first accepted bit lands in data_out[WIDTH-1].
REQ-004 SHALL have port clock_100KHz  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  1  serial data bit.
REQ-007 SHALL have port write_in  input  1  data_in is valid this cycle.
REQ-008 SHALL have port status_out  output  1  high = block can accept a bit this cycle.
REQ-009 SHALL have port data_out  output  WIDTH  oldest completed word (buffer head).
REQ-010 SHALL have port data_ready  output  1  high = data_out holds a valid word.
REQ-011 SHALL have port ack_in  input  1  consumer takes the word on data_out.
REQ-012 SHALL have port level  output  $clog2(DEPTH+1)  number of words in the buffer.
REQ-013 SHALL have port overrun  output  1  sticky flag: write_in was asserted while status_out was low.
REQ-014 SHALL have port clear_overrun  input  1  clears overrun.

Function
REQ-015 SHALL accept a bit at a rising edge only when write_in=1 and status_out=1; accepted bits increment an internal bit counter 0..WIDTH-1.
REQ-016 SHALL place accepted bit k (k = 0..WIDTH-1 in arrival order) at word index k when MSB_FIRST=0, at index WIDTH-1-k when MSB_FIRST=1.
REQ-017 SHALL, on acceptance of the WIDTH-th bit, write the completed word into the buffer tail and reset the bit counter to 0 at that same edge.
REQ-018 SHALL drive status_out = 1 exactly when level < DEPTH (combinational from level); a partially assembled word does not block acceptance.
REQ-019 SHALL drive data_ready = 1 exactly when level > 0, and data_out = buffer head; data_out SHALL be all zeros when level = 0.
REQ-020 SHALL make a completed word visible on data_out/data_ready in the cycle immediately after the edge that accepted its last bit (1-cycle latency), when the buffer was empty.
REQ-021 SHALL remove the head word at a rising edge when ack_in=1 and data_ready=1; ack_in while data_ready=0 SHALL be ignored.
REQ-022 SHALL, on a push and pop at the same edge, leave level unchanged and present the next-oldest word (or the newly pushed word if it was the only one left).
REQ-023 SHALL preserve word order (FIFO); head/tail pointers wrap modulo DEPTH.
REQ-024 SHALL, when write_in=1 and status_out=0, drop the bit (no counter or buffer change) and set overrun=1 at that edge.
REQ-025 SHALL clear overrun on clear_overrun=1; if clear_overrun and a new overrun event coincide, overrun SHALL end high.
REQ-026 SHALL never let level exceed DEPTH or underflow below 0.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, clear bit counter, partial word, buffer pointers, level and overrun, overriding all other inputs that cycle.
REQ-028 SHALL present after reset: data_out=0, data_ready=0, level=0, overrun=0, status_out=1.
REQ-029 SHALL discard any partially assembled word on reset mid-word; the next accepted bit is bit 0 of a fresh word.

Verification
REQ-030 SHALL cover, WIDTH=8, MSB_FIRST=0: bits 1,0,1,1,0,0,1,0 on consecutive write_in cycles -> next cycle data_out=0x4D, data_ready=1, level=1.
REQ-031 SHALL cover, MSB_FIRST=1: same bit sequence -> data_out=0xB2.
REQ-032 SHALL cover, DEPTH=2: two full words, no ack -> level=2, status_out=0; one extra write_in -> overrun=1, level=2, data_out still first word; clear_overrun -> overrun=0.
REQ-033 SHALL cover: level=1 (word 0x11), last bit of word 0x22 accepted at same edge as ack_in -> level=1, data_out=0x22.
REQ-034 SHALL cover: 5 bits accepted, reset pulse, then bits of 0xA5 -> data_out=0xA5, level=1.
REQ-035 SHALL cover: ack_in held high with level=0 -> level stays 0, data_ready=0, data_out=0.
